// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph table, blank pattern and mode/direction encodings
package seg7_pkg;

    typedef enum logic {
        MODE_SWITCH = 1'b0,
        MODE_COUNT  = 1'b1
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Entry n is the active-high a..g pattern for hex digit n (bit0 = a).
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - 4-bit to 7-segment decoder with range flag
// SEG7_BLANK_INVALID_EN: when defined, values >= MODULUS decode to a blank display.
module seg7_decode
    import seg7_pkg::*;
#(
    parameter int MODULUS = 10
) (
    input  logic [3:0] value,
    output logic [6:0] seg,
    output logic       out_of_range
);

    assign out_of_range = ({1'b0, value} >= 5'(MODULUS));

`ifdef SEG7_BLANK_INVALID_EN
    assign seg = out_of_range ? SEG_BLANK : GLYPH_TABLE[value];
`else
    assign seg = GLYPH_TABLE[value];
`endif

endmodule

// File: rtl/seg7_mod_counter.sv
// rtl/seg7_mod_counter.sv - prescaled modulo up/down digit counter with registered 7-segment output
// SEG7_BLANK_INVALID_EN: when defined, displayed values >= MODULUS blank the segments.
module seg7_mod_counter
    import seg7_pkg::*;
#(
    parameter int DIV_W   = 10,
    parameter int DIV_MAX = 999,
    parameter int MODULUS = 10
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    if (MODULUS < 2 || MODULUS > 16) begin : g_bad_modulus
        $error("seg7_mod_counter: MODULUS must be within 2..16");
    end
    if (DIV_W < 1 || DIV_W > 31 || DIV_MAX < 0 || DIV_MAX >= (1 << DIV_W)) begin : g_bad_div
        $error("seg7_mod_counter: DIV_MAX must fit in DIV_W bits");
    end

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV_MAX);
    localparam logic [3:0]       DIGIT_LAST = 4'(MODULUS - 1);

    logic       clk;
    logic       rst;
    mode_e      mode;
    dir_e       dir;
    logic [3:0] sw;

    assign clk  = io_in[0];
    assign rst  = io_in[1];
    assign mode = mode_e'(io_in[2]);
    assign dir  = dir_e'(io_in[3]);
    assign sw   = io_in[7:4];

    logic [DIV_W-1:0] div_cnt;
    logic [3:0]       digit;
    logic             carry;
    logic             tick;
    logic [3:0]       digit_next;
    logic             wrap;
    logic [3:0]       disp;
    logic [6:0]       seg;
    logic             disp_invalid;
    logic             flag_next;

    assign tick = (mode == MODE_COUNT) && (div_cnt == DIV_LAST);

    always_comb begin
        digit_next = digit;
        wrap       = 1'b0;
        if (dir == DIR_DOWN) begin
            wrap       = (digit == 4'd0);
            digit_next = wrap ? DIGIT_LAST : digit - 4'd1;
        end else begin
            wrap       = (digit == DIGIT_LAST);
            digit_next = wrap ? 4'd0 : digit + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            digit   <= 4'd0;
            carry   <= 1'b0;
        end else if (mode == MODE_SWITCH) begin
            // In switch mode disp is sw, so the decoder's range flag doubles as the preset check.
            div_cnt <= '0;
            digit   <= disp_invalid ? 4'd0 : sw;
            carry   <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            digit   <= digit_next;
            carry   <= wrap;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign disp      = (mode == MODE_COUNT) ? digit : sw;
    assign flag_next = (mode == MODE_COUNT) ? carry : disp_invalid;

    seg7_decode #(
        .MODULUS(MODULUS)
    ) u_decode (
        .value       (disp),
        .seg         (seg),
        .out_of_range(disp_invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            io_out <= {1'b0, GLYPH_TABLE[0]};
        end else begin
            io_out <= {flag_next, seg};
        end
    end

endmodule

// File: tb/tb_seg7_mod_counter.sv
// tb/tb_seg7_mod_counter.sv - scoreboard bench for seg7_mod_counter (MODULUS 10 and 16 instances)
module tb_seg7_mod_counter;

    localparam int DIV_MAX = 3;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       mode = 1'b1;
    logic       dir  = 1'b0;
    logic [3:0] sw   = 4'd0;
    logic [7:0] io_out;
    logic [7:0] io_out16;

    int errors = 0;
    int checks = 0;

    logic [7:0] q10[$];
    logic [7:0] q16[$];

    typedef struct {
        int div;
        int digit;
        bit carry;
    } mstate_t;

    mstate_t m10 = '{0, 0, 1'b0};
    mstate_t m16 = '{0, 0, 1'b0};

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    seg7_mod_counter #(.DIV_W(4), .DIV_MAX(DIV_MAX), .MODULUS(10)) dut (
        .io_in ({sw, dir, mode, rst, clk}),
        .io_out(io_out)
    );

    seg7_mod_counter #(.DIV_W(4), .DIV_MAX(DIV_MAX), .MODULUS(16)) dut16 (
        .io_in ({sw, dir, mode, rst, clk}),
        .io_out(io_out16)
    );

    initial forever #5 clk = ~clk;

    task automatic model_step(input int modn, inout mstate_t s, output logic [7:0] out);
        int         disp;
        bit         fl;
        logic [6:0] g;
        if (rst) begin
            s.div = 0; s.digit = 0; s.carry = 1'b0;
            out = 8'h3F;
            return;
        end
        disp = mode ? s.digit : int'(sw);
        fl   = mode ? s.carry : (int'(sw) >= modn);
        g    = glyph_tab[disp];
`ifdef SEG7_BLANK_INVALID_EN
        if (disp >= modn) g = 7'h00;
`endif
        out = {fl, g};
        if (!mode) begin
            s.div = 0;
            s.digit = (int'(sw) < modn) ? int'(sw) : 0;
            s.carry = 1'b0;
        end else if (s.div == DIV_MAX) begin
            s.div = 0;
            if (!dir) begin
                if (s.digit == modn - 1) begin s.digit = 0; s.carry = 1'b1; end
                else begin s.digit = s.digit + 1; s.carry = 1'b0; end
            end else begin
                if (s.digit == 0) begin s.digit = modn - 1; s.carry = 1'b1; end
                else begin s.digit = s.digit - 1; s.carry = 1'b0; end
            end
        end else begin
            s.div = s.div + 1;
        end
    endtask

    task automatic cyc();
        logic [7:0] e;
        model_step(10, m10, e);
        q10.push_back(e);
        model_step(16, m16, e);
        q16.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin : scoreboard
        logic [7:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (q10.size() > 0) begin
                e = q10.pop_front();
                checks++;
                if (io_out !== e) begin
                    errors++;
                    $display("FAIL sb_mod10 t=%0t got=%h exp=%h", $time, io_out, e);
                end
            end
            if (q16.size() > 0) begin
                e = q16.pop_front();
                checks++;
                if (io_out16 !== e) begin
                    errors++;
                    $display("FAIL sb_mod16 t=%0t got=%h exp=%h", $time, io_out16, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; mode = 1'b1; dir = 1'b0; sw = 4'd0;
        cyc();
        cyc();
        checks++;
        if (io_out !== 8'h3F || io_out16 !== 8'h3F) begin
            errors++;
            $display("FAIL reset_value got=%h/%h exp=3f", io_out, io_out16);
        end
    endtask

    task automatic test_count_up();
        rst = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            if (i == 4) begin
                checks++;
                if (io_out !== 8'h3F) begin
                    errors++;
                    $display("FAIL before_first_tick got=%h exp=3f", io_out);
                end
            end
        end
        checks++;
        if (io_out !== 8'h06) begin
            errors++;
            $display("FAIL first_tick_digit1 got=%h exp=06", io_out);
        end
    endtask

    task automatic test_wrap_up();
        for (int i = 0; i < 35; i++) cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            checks++;
            if (io_out !== 8'hBF) begin
                errors++;
                $display("FAIL wrap_up_flag cycle=%0d got=%h exp=bf", i, io_out);
            end
        end
        cyc();
        checks++;
        if (io_out !== 8'h06) begin
            errors++;
            $display("FAIL wrap_up_flag_clear got=%h exp=06", io_out);
        end
    endtask

    task automatic test_wrap_down();
        rst = 1'b1;
        cyc();
        rst = 1'b0; mode = 1'b1; dir = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            cyc();
            if (e == 5 && io_out !== 8'hEF) begin
                errors++;
                $display("FAIL wrap_down_9 got=%h exp=ef", io_out);
            end
            if (e == 9 && io_out !== 8'h7F) begin
                errors++;
                $display("FAIL down_8 got=%h exp=7f", io_out);
            end
            if (e == 13 && io_out !== 8'h07) begin
                errors++;
                $display("FAIL down_7 got=%h exp=07", io_out);
            end
            if (e == 16 && io_out !== 8'h07) begin
                errors++;
                $display("FAIL dir_change_no_step got=%h exp=07", io_out);
            end
            if (e == 17 && io_out !== 8'h7F) begin
                errors++;
                $display("FAIL dir_change_at_tick got=%h exp=7f", io_out);
            end
            if (e == 5 || e == 9 || e == 13 || e == 16 || e == 17) checks++;
            if (e == 13) dir = 1'b0;
        end
    endtask

    task automatic test_switch();
        logic [7:0] exp_c;
`ifdef SEG7_BLANK_INVALID_EN
        exp_c = 8'h80;
`else
        exp_c = 8'hB9;
`endif
        mode = 1'b0; sw = 4'hC; dir = 1'b0;
        cyc();
        checks++;
        if (io_out !== exp_c) begin
            errors++;
            $display("FAIL switch_invalid got=%h exp=%h", io_out, exp_c);
        end
        checks++;
        if (io_out16 !== 8'h39) begin
            errors++;
            $display("FAIL switch_c_mod16 got=%h exp=39", io_out16);
        end
        mode = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            if (e == 1) begin
                checks++;
                if (io_out !== 8'h3F) begin
                    errors++;
                    $display("FAIL switch_to_count_0 got=%h exp=3f", io_out);
                end
            end
        end
        checks++;
        if (io_out !== 8'h06) begin
            errors++;
            $display("FAIL switch_to_count_1 got=%h exp=06", io_out);
        end
    endtask

    task automatic test_preset_reset();
        mode = 1'b0; sw = 4'd5; dir = 1'b0;
        cyc();
        checks++;
        if (io_out !== 8'h6D) begin
            errors++;
            $display("FAIL preset_5 got=%h exp=6d", io_out);
        end
        mode = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            cyc();
            checks++;
            if (io_out !== ((e <= 4) ? 8'h6D : 8'h7D)) begin
                errors++;
                $display("FAIL preset_count e=%0d got=%h exp=%h", e, io_out, (e <= 4) ? 8'h6D : 8'h7D);
            end
        end
        cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if (io_out !== 8'h3F) begin
            errors++;
            $display("FAIL mid_count_reset got=%h exp=3f", io_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_modulus16();
        logic [7:0] seq [7] = '{8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'hBF};
        mode = 1'b0; sw = 4'hA; dir = 1'b0;
        cyc();
        mode = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            cyc();
            if (e % 4 == 1) begin
                checks++;
                if (io_out16 !== seq[(e - 1) / 4]) begin
                    errors++;
                    $display("FAIL mod16_seq e=%0d got=%h exp=%h", e, io_out16, seq[(e - 1) / 4]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 24) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) dir = ~dir;
            if ($urandom_range(0, 3) == 0) sw = 4'($urandom_range(0, 15));
            cyc();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_switch();
        test_preset_reset();
        test_modulus16();
        test_back_to_back();
        #2;
        checks++;
        if (q10.size() != 0 || q16.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", q10.size(), q16.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
